// File: rtl/dp_lat_pkg.sv
// Shared types and Hamming SECDED helpers for dual_port_lat_ram.
// Codeword layout: bit 0 = overall parity, bits 1..HBITS = Hamming positions.
package dp_lat_pkg;

    localparam int DP_DATA_WIDTH = 4;
    localparam int DP_MEM_DEPTH  = 32;
    localparam int DP_ADDR_WIDTH = $clog2(DP_MEM_DEPTH);

    typedef struct packed {
        logic                     we;
        logic [DP_ADDR_WIDTH-1:0] addr;
        logic [DP_DATA_WIDTH-1:0] wdata;
    } op_t;

    function automatic int ECC_PBITS(input int dw);
        int p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    localparam int DP_PBITS    = ECC_PBITS(DP_DATA_WIDTH);
    localparam int DP_HBITS    = DP_DATA_WIDTH + DP_PBITS;
    localparam int DP_CW_WIDTH = DP_HBITS + 1;

    typedef logic [DP_CW_WIDTH-1:0] cw_t;

    typedef struct packed {
        logic [DP_DATA_WIDTH-1:0] data;
        logic                     sbe;
        logic                     dbe;
    } dec_t;

    function automatic cw_t secded_enc(input logic [DP_DATA_WIDTH-1:0] d);
        cw_t  cw;
        int   j;
        logic p;
        cw = '0;
        j  = 0;
        for (int i = 1; i <= DP_HBITS; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j++;
            end
        end
        for (int k = 0; k < DP_PBITS; k++) begin
            p = 1'b0;
            for (int i = 1; i <= DP_HBITS; i++) begin
                if (((i >> k) & 1) == 1) p ^= cw[i];
            end
            cw[1 << k] = p;
        end
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic dec_t secded_dec(input cw_t cw_in);
        cw_t  cw;
        dec_t r;
        int   syn;
        int   j;
        logic p;
        cw  = cw_in;
        syn = 0;
        r   = '0;
        for (int k = 0; k < DP_PBITS; k++) begin
            p = 1'b0;
            for (int i = 1; i <= DP_HBITS; i++) begin
                if (((i >> k) & 1) == 1) p ^= cw[i];
            end
            if (p) syn |= (1 << k);
        end
        // Odd overall parity means one flipped bit; syndrome 0 points at the parity bit itself
        if (^cw) begin
            if (syn > DP_HBITS) begin
                r.dbe = 1'b1;
            end else begin
                r.sbe = 1'b1;
                if (syn != 0) cw[syn] = ~cw[syn];
            end
        end else if (syn != 0) begin
            r.dbe = 1'b1;
        end
        j = 0;
        for (int i = 1; i <= DP_HBITS; i++) begin
            if ((i & (i - 1)) != 0) begin
                r.data[j] = cw[i];
                j++;
            end
        end
        return r;
    endfunction

    function automatic logic addr_ok(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/lat_pipe.sv
// Fixed-latency valid-tagged shift register; payload appears LAT edges after capture.
// Synchronous clear drops every in-flight entry; payload registers carry no reset.
module lat_pipe #(
    parameter int  LAT = 1,
    parameter type T   = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_vld_i,
    input  T     in_dat_i,
    output logic out_vld_o,
    output T     out_dat_o
);

    logic [LAT-1:0] vld_q;
    T               dat_q [LAT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        dat_q[0] <= in_dat_i;
        for (int i = 1; i < LAT; i++) dat_q[i] <= dat_q[i-1];
    end

    assign out_vld_o = vld_q[LAT-1];
    assign out_dat_o = dat_q[LAT-1];

endmodule

// File: rtl/dual_port_lat_ram.sv
// True dual-port RAM with per-port write/read latency, no backpressure, port A wins commit collisions.
// Define DPRAM_ECC_EN to store Hamming SECDED codewords (same latency, sbe/dbe flags on reads).
module dual_port_lat_ram
    import dp_lat_pkg::*;
#(
    parameter int DATA_WIDTH  = DP_DATA_WIDTH,
    parameter int MEM_DEPTH   = DP_MEM_DEPTH,
    parameter int ADDR_WIDTH  = $clog2(MEM_DEPTH),
    parameter int WR_LATENCYA = 10,
    parameter int RD_LATENCYA = 5,
    parameter int WR_LATENCYB = 7,
    parameter int RD_LATENCYB = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  a_en_i,
    input  logic                  a_we_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_wdata_i,
    output logic [DATA_WIDTH-1:0] a_rdata_o,
    output logic                  a_rvalid_o,
    output logic                  a_sbe_o,
    output logic                  a_dbe_o,
    input  logic                  b_en_i,
    input  logic                  b_we_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_wdata_i,
    output logic [DATA_WIDTH-1:0] b_rdata_o,
    output logic                  b_rvalid_o,
    output logic                  b_sbe_o,
    output logic                  b_dbe_o
);

`ifdef DPRAM_ECC_EN
    localparam int WORD_WIDTH = DP_CW_WIDTH;
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif
    typedef logic [WORD_WIDTH-1:0] word_t;

    function automatic word_t store_word(input logic [DATA_WIDTH-1:0] d);
`ifdef DPRAM_ECC_EN
        return secded_enc(d);
`else
        return d;
`endif
    endfunction

    function automatic dec_t load_word(input word_t w);
`ifdef DPRAM_ECC_EN
        return secded_dec(w);
`else
        dec_t r;
        r.data = w;
        r.sbe  = 1'b0;
        r.dbe  = 1'b0;
        return r;
`endif
    endfunction

    word_t mem [MEM_DEPTH];

    op_t   a_wop, b_wop, a_wout, b_wout;
    logic  a_wout_vld, b_wout_vld;
    word_t a_rsamp, b_rsamp, a_rout, b_rout;
    logic  a_rout_vld, b_rout_vld;
    logic  a_commit, b_commit;
    dec_t  a_dec, b_dec;

    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic a_rvalid_q, a_rvalid_d, a_sbe_q, a_sbe_d, a_dbe_q, a_dbe_d;
    logic b_rvalid_q, b_rvalid_d, b_sbe_q, b_sbe_d, b_dbe_q, b_dbe_d;

    assign a_wop = '{we: a_we_i, addr: a_addr_i, wdata: a_wdata_i};
    assign b_wop = '{we: b_we_i, addr: b_addr_i, wdata: b_wdata_i};

    // Out-of-range reads return zero, which is also a clean codeword
    always_comb begin
        a_rsamp = '0;
        b_rsamp = '0;
        if (addr_ok(32'(a_addr_i), MEM_DEPTH)) a_rsamp = mem[a_addr_i];
        if (addr_ok(32'(b_addr_i), MEM_DEPTH)) b_rsamp = mem[b_addr_i];
    end

    lat_pipe #(.LAT(WR_LATENCYA), .T(op_t)) u_a_wr (
        .clk_i, .rst_i, .in_vld_i(a_en_i & a_we_i), .in_dat_i(a_wop),
        .out_vld_o(a_wout_vld), .out_dat_o(a_wout));
    lat_pipe #(.LAT(WR_LATENCYB), .T(op_t)) u_b_wr (
        .clk_i, .rst_i, .in_vld_i(b_en_i & b_we_i), .in_dat_i(b_wop),
        .out_vld_o(b_wout_vld), .out_dat_o(b_wout));
    lat_pipe #(.LAT(RD_LATENCYA), .T(word_t)) u_a_rd (
        .clk_i, .rst_i, .in_vld_i(a_en_i & ~a_we_i), .in_dat_i(a_rsamp),
        .out_vld_o(a_rout_vld), .out_dat_o(a_rout));
    lat_pipe #(.LAT(RD_LATENCYB), .T(word_t)) u_b_rd (
        .clk_i, .rst_i, .in_vld_i(b_en_i & ~b_we_i), .in_dat_i(b_rsamp),
        .out_vld_o(b_rout_vld), .out_dat_o(b_rout));

    assign a_commit = a_wout_vld & a_wout.we & addr_ok(32'(a_wout.addr), MEM_DEPTH);
    assign b_commit = b_wout_vld & b_wout.we & addr_ok(32'(b_wout.addr), MEM_DEPTH)
                    & ~(a_commit & (a_wout.addr == b_wout.addr));

    // A commit landing on a reset edge is still in flight and is dropped
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (a_commit) mem[a_wout.addr] <= store_word(a_wout.wdata);
            if (b_commit) mem[b_wout.addr] <= store_word(b_wout.wdata);
        end
    end

    always_comb begin
        a_dec      = load_word(a_rout);
        b_dec      = load_word(b_rout);
        a_rvalid_d = a_rout_vld;
        a_rdata_d  = a_rout_vld ? a_dec.data : '0;
        a_sbe_d    = a_rout_vld & a_dec.sbe;
        a_dbe_d    = a_rout_vld & a_dec.dbe;
        b_rvalid_d = b_rout_vld;
        b_rdata_d  = b_rout_vld ? b_dec.data : '0;
        b_sbe_d    = b_rout_vld & b_dec.sbe;
        b_dbe_d    = b_rout_vld & b_dec.dbe;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            a_sbe_q    <= 1'b0;
            a_dbe_q    <= 1'b0;
            b_rvalid_q <= 1'b0;
            b_rdata_q  <= '0;
            b_sbe_q    <= 1'b0;
            b_dbe_q    <= 1'b0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            a_sbe_q    <= a_sbe_d;
            a_dbe_q    <= a_dbe_d;
            b_rvalid_q <= b_rvalid_d;
            b_rdata_q  <= b_rdata_d;
            b_sbe_q    <= b_sbe_d;
            b_dbe_q    <= b_dbe_d;
        end
    end

    assign a_rvalid_o = a_rvalid_q;
    assign a_rdata_o  = a_rdata_q;
    assign a_sbe_o    = a_sbe_q;
    assign a_dbe_o    = a_dbe_q;
    assign b_rvalid_o = b_rvalid_q;
    assign b_rdata_o  = b_rdata_q;
    assign b_sbe_o    = b_sbe_q;
    assign b_dbe_o    = b_dbe_q;

endmodule

// File: tb/tb_dual_port_lat_ram.sv
// Bench for dual_port_lat_ram: directed scenarios plus random traffic against an edge-indexed schedule model.
module tb_dual_port_lat_ram;

    localparam int DW = 4, DEPTH = 32, AW = 5;
    localparam int WRA = 10, RDA = 5, WRB = 7, RDB = 8;
    localparam int NE = 2048;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          a_en, a_we, b_en, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
    logic          a_rvalid, a_sbe, a_dbe, b_rvalid, b_sbe, b_dbe;

    dual_port_lat_ram dut (
        .clk_i(clk), .rst_i(rst),
        .a_en_i(a_en), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_rdata_o(a_rdata), .a_rvalid_o(a_rvalid), .a_sbe_o(a_sbe), .a_dbe_o(a_dbe),
        .b_en_i(b_en), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_rdata_o(b_rdata), .b_rvalid_o(b_rvalid), .b_sbe_o(b_sbe), .b_dbe_o(b_dbe));

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference state: memory contents, injected-error count per word, and per-edge schedules
    logic [DW-1:0] mm [DEPTH];
    int            merr [DEPTH];
    logic          a_ev [NE], b_ev [NE], a_es [NE], b_es [NE], a_eb [NE], b_eb [NE];
    logic [DW-1:0] a_ed [NE], b_ed [NE], a_cd [NE], b_cd [NE];
    logic          a_cv [NE], b_cv [NE];
    logic [AW-1:0] a_ca [NE], b_ca [NE];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = edge_n; i < NE; i++) begin
                a_ev[i] = 1'b0; b_ev[i] = 1'b0; a_cv[i] = 1'b0; b_cv[i] = 1'b0;
            end
            return;
        end
        // Reads see the array as it was before this edge's commits
        if (a_en && !a_we) begin
            a_ev[edge_n+RDA] = 1'b1;
            a_ed[edge_n+RDA] = mm[a_addr];
            a_es[edge_n+RDA] = (merr[a_addr] == 1);
            a_eb[edge_n+RDA] = (merr[a_addr] == 2);
        end
        if (b_en && !b_we) begin
            b_ev[edge_n+RDB] = 1'b1;
            b_ed[edge_n+RDB] = mm[b_addr];
            b_es[edge_n+RDB] = (merr[b_addr] == 1);
            b_eb[edge_n+RDB] = (merr[b_addr] == 2);
        end
        if (b_cv[edge_n]) begin
            mm[b_ca[edge_n]]   = b_cd[edge_n];
            merr[b_ca[edge_n]] = 0;
        end
        if (a_cv[edge_n]) begin
            mm[a_ca[edge_n]]   = a_cd[edge_n];
            merr[a_ca[edge_n]] = 0;
        end
        if (a_en && a_we) begin
            a_cv[edge_n+WRA] = 1'b1; a_ca[edge_n+WRA] = a_addr; a_cd[edge_n+WRA] = a_wdata;
        end
        if (b_en && b_we) begin
            b_cv[edge_n+WRB] = 1'b1; b_ca[edge_n+WRB] = b_addr; b_cd[edge_n+WRB] = b_wdata;
        end
    endtask

    task automatic check_outputs(input logic rst_at);
        chk($sformatf("a_rvalid@e%0d", edge_n), 32'(a_rvalid), 32'(a_ev[edge_n]));
        chk($sformatf("b_rvalid@e%0d", edge_n), 32'(b_rvalid), 32'(b_ev[edge_n]));
        if (a_ev[edge_n]) chk($sformatf("a_rdata@e%0d", edge_n), 32'(a_rdata), 32'(a_ed[edge_n]));
        if (b_ev[edge_n]) chk($sformatf("b_rdata@e%0d", edge_n), 32'(b_rdata), 32'(b_ed[edge_n]));
        chk($sformatf("a_sbe@e%0d", edge_n), 32'(a_sbe), 32'(a_ev[edge_n] & a_es[edge_n]));
        chk($sformatf("a_dbe@e%0d", edge_n), 32'(a_dbe), 32'(a_ev[edge_n] & a_eb[edge_n]));
        chk($sformatf("b_sbe@e%0d", edge_n), 32'(b_sbe), 32'(b_ev[edge_n] & b_es[edge_n]));
        chk($sformatf("b_dbe@e%0d", edge_n), 32'(b_dbe), 32'(b_ev[edge_n] & b_eb[edge_n]));
        if (rst_at) begin
            chk($sformatf("a_rdata_rst@e%0d", edge_n), 32'(a_rdata), 32'd0);
            chk($sformatf("b_rdata_rst@e%0d", edge_n), 32'(b_rdata), 32'd0);
        end
    endtask

    task automatic tick();
        logic rst_at;
        @(posedge clk);
        rst_at = rst;
        model_edge();
        #1;
        check_outputs(rst_at);
        edge_n++;
        a_en = 1'b0;
        b_en = 1'b0;
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic reqa(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        a_en = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
    endtask

    task automatic reqb(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] d);
        b_en = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < NE; i++) begin
            a_ev[i] = 1'b0; b_ev[i] = 1'b0; a_es[i] = 1'b0; b_es[i] = 1'b0;
            a_eb[i] = 1'b0; b_eb[i] = 1'b0; a_cv[i] = 1'b0; b_cv[i] = 1'b0;
            a_ed[i] = '0;   b_ed[i] = '0;   a_cd[i] = '0;   b_cd[i] = '0;
            a_ca[i] = '0;   b_ca[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            mm[i]   = 'x;
            merr[i] = 0;
        end
        rst = 1'b1;
        a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

        wait_n(2);
        rst = 1'b0;

        // Give every word a known value before anything reads it
        for (int i = 0; i < DEPTH; i++) begin
            reqa(1'b1, AW'(i), DW'(i * 7 + 3));
            tick();
        end
        wait_n(12);

        // Read-before-write at the commit edge, new data one edge later
        reqa(1'b1, 5'd3, 4'hA); tick();
        wait_n(9);
        reqb(1'b0, 5'd3, 4'h0); tick();
        reqb(1'b0, 5'd3, 4'h0); tick();
        wait_n(12);

        // Same-edge commit collision: port A wins
        reqa(1'b1, 5'd5, 4'h1); tick();
        wait_n(2);
        reqb(1'b1, 5'd5, 4'h2); tick();
        wait_n(8);
        reqa(1'b0, 5'd5, 4'h0); tick();
        wait_n(8);

        // Back-to-back reads across the whole array
        for (int i = 0; i < DEPTH; i++) begin
            reqa(1'b0, AW'(i), 4'h0);
            tick();
        end
        wait_n(8);

        // Mid-flight reset kills a pending write and a pending read; request on the reset edge is dropped
        reqa(1'b1, 5'd7, 4'hF); tick();
        reqb(1'b0, 5'd7, 4'h0); tick();
        wait_n(2);
        rst = 1'b1;
        reqb(1'b1, 5'd7, 4'h3); tick();
        tick();
        rst = 1'b0;
        wait_n(8);
        reqa(1'b0, 5'd7, 4'h0); tick();
        wait_n(8);

        // Same-address read on both ports, each at its own latency
        reqa(1'b0, 5'd9, 4'h0);
        reqb(1'b0, 5'd9, 4'h0);
        tick();
        wait_n(10);

`ifdef DPRAM_ECC_EN
        reqa(1'b1, 5'd12, 4'h6); tick();
        wait_n(11);
        dut.mem[12][3] = ~dut.mem[12][3];
        merr[12] = 1;
        reqa(1'b0, 5'd12, 4'h0); tick();
        wait_n(6);
        dut.mem[12][3] = ~dut.mem[12][3];
        dut.mem[12][1] = ~dut.mem[12][1];
        dut.mem[12][2] = ~dut.mem[12][2];
        merr[12] = 2;
        reqb(1'b0, 5'd12, 4'h0); tick();
        wait_n(9);
`endif

        // Random traffic over a narrow address window to provoke collisions, with sporadic resets
        repeat (400) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) != 0)
                reqa(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom()));
            if ($urandom_range(0, 3) != 0)
                reqb(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom()));
            tick();
        end
        rst = 1'b0;
        wait_n(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
